// File: rtl/plate_box_overlay.sv
// Draws a rectangular border around the detected plate onto an RGB888 video stream.
// One box is latched per frame at frame start; short detection dropouts keep the last good box.
module plate_box_overlay #(
    parameter logic [23:0] BOX_COLOR   = 24'hFF0000,
    parameter int          THICK       = 2,
    parameter int          MIN_W       = 16,
    parameter int          MIN_H       = 8,
    parameter int          HOLD_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic [23:0] i_data,
    input  logic [11:0] edge_left,
    input  logic [11:0] edge_right,
    input  logic [11:0] edge_up,
    input  logic [11:0] edge_down,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [23:0] o_data,
    output logic        box_valid,
    output logic [15:0] drop_cnt
);

    localparam logic [12:0] THICK_C = 13'(THICK);
    localparam logic [12:0] TWO_T_C = 13'(2 * THICK);
    localparam logic [12:0] MIN_W_C = 13'(MIN_W);
    localparam logic [12:0] MIN_H_C = 13'(MIN_H);
    localparam logic [15:0] HOLD_C  = 16'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        ST_NO_BOX = 2'd0,
        ST_SHOW   = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_hold_cnt;
    logic        r_vs_d;
    logic [11:0] r_left, r_right, r_up, r_down;
    logic        r_box_valid;
    logic [15:0] r_drop_cnt;
    logic        r_s1_hs, r_s1_vs, r_s1_de, r_s1_draw;
    logic [23:0] r_s1_data;
    logic        r_o_hs, r_o_vs, r_o_de;
    logic [23:0] r_o_data;

    logic        w_fs;
    logic [11:0] w_width, w_height;
    logic        w_valid;
    state_t      w_next_state;
    logic [15:0] w_next_hold;
    logic        w_load;
    logic [12:0] w_l, w_r, w_u, w_d, w_x, w_y;
    logic        w_show, w_outer, w_inner;

    assign w_fs     = i_vs & ~r_vs_d;
    assign w_width  = edge_right - edge_left;
    assign w_height = edge_down - edge_up;

    // Edge validity: size limits only apply once ordering is known, so differences never wrap
    always_comb begin
        w_valid = 1'b0;
        if ((edge_left < edge_right) && (edge_up < edge_down)) begin
            w_valid = ({1'b0, w_width}  >= MIN_W_C) && ({1'b0, w_height} >= MIN_H_C) &&
                      ({1'b0, w_width}  >= TWO_T_C) && ({1'b0, w_height} >= TWO_T_C);
        end else begin
            w_valid = 1'b0;
        end
    end

    // Next box state, evaluated only on the frame-start cycle
    always_comb begin
        w_next_state = r_state;
        w_next_hold  = r_hold_cnt;
        w_load       = 1'b0;
        if (w_fs) begin
            if (w_valid) begin
                w_next_state = ST_SHOW;
                w_next_hold  = 16'd0;
                w_load       = 1'b1;
            end else begin
                case (r_state)
                    ST_NO_BOX: begin
                        w_next_state = ST_NO_BOX;
                        w_next_hold  = 16'd0;
                    end
                    ST_SHOW: begin
                        if (HOLD_C == 16'd0) begin
                            w_next_state = ST_NO_BOX;
                            w_next_hold  = 16'd0;
                        end else begin
                            w_next_state = ST_HOLD;
                            w_next_hold  = 16'd1;
                        end
                    end
                    ST_HOLD: begin
                        if (r_hold_cnt >= HOLD_C) begin
                            w_next_state = ST_NO_BOX;
                            w_next_hold  = 16'd0;
                        end else begin
                            w_next_state = ST_HOLD;
                            w_next_hold  = r_hold_cnt + 16'd1;
                        end
                    end
                    default: begin
                        w_next_state = ST_NO_BOX;
                        w_next_hold  = 16'd0;
                    end
                endcase
            end
        end else begin
            w_next_state = r_state;
            w_next_hold  = r_hold_cnt;
            w_load       = 1'b0;
        end
    end

    // The frame-start pixel already sees the freshly loaded box; 13-bit sums cannot wrap
    assign w_l     = {1'b0, (w_load ? edge_left  : r_left)};
    assign w_r     = {1'b0, (w_load ? edge_right : r_right)};
    assign w_u     = {1'b0, (w_load ? edge_up    : r_up)};
    assign w_d     = {1'b0, (w_load ? edge_down  : r_down)};
    assign w_x     = {1'b0, i_x};
    assign w_y     = {1'b0, i_y};
    assign w_show  = (w_next_state != ST_NO_BOX);
    assign w_outer = (w_x >= w_l) && (w_x <= w_r) && (w_y >= w_u) && (w_y <= w_d);
    assign w_inner = (w_x >= w_l + THICK_C) && (w_x + THICK_C <= w_r) &&
                     (w_y >= w_u + THICK_C) && (w_y + THICK_C <= w_d);

    // Box state, frame bookkeeping and the two-stage overlay pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_NO_BOX;
            r_hold_cnt  <= 16'd0;
            r_vs_d      <= 1'b0;
            r_left      <= 12'd0;
            r_right     <= 12'd0;
            r_up        <= 12'd0;
            r_down      <= 12'd0;
            r_box_valid <= 1'b0;
            r_drop_cnt  <= 16'd0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_draw   <= 1'b0;
            r_s1_data   <= 24'd0;
            r_o_hs      <= 1'b0;
            r_o_vs      <= 1'b0;
            r_o_de      <= 1'b0;
            r_o_data    <= 24'd0;
        end else begin
            r_vs_d      <= i_vs;
            r_state     <= w_next_state;
            r_hold_cnt  <= w_next_hold;
            r_box_valid <= w_show;
            if (w_load) begin
                r_left  <= edge_left;
                r_right <= edge_right;
                r_up    <= edge_up;
                r_down  <= edge_down;
            end
            if (w_fs && !w_valid && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            r_s1_hs   <= i_hs;
            r_s1_vs   <= i_vs;
            r_s1_de   <= i_de;
            r_s1_data <= i_data;
            r_s1_draw <= w_show & i_de & w_outer & ~w_inner;
            r_o_hs    <= r_s1_hs;
            r_o_vs    <= r_s1_vs;
            r_o_de    <= r_s1_de;
            r_o_data  <= r_s1_draw ? BOX_COLOR : r_s1_data;
        end
    end

    assign o_hs      = r_o_hs;
    assign o_vs      = r_o_vs;
    assign o_de      = r_o_de;
    assign o_data    = r_o_data;
    assign box_valid = r_box_valid;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_plate_box_overlay.sv
// Bench for plate_box_overlay: two instances (default, and MIN_W=4 / HOLD_FRAMES=0) share the
// video stream; a behavioural model fills a scoreboard, and a frame table holds status expectations.
module tb_plate_box_overlay;

    localparam logic [23:0] BOX = 24'hFF0000;
    localparam int T = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hs, vs, de;
    logic [11:0] x, y;
    logic [23:0] data;
    logic [11:0] el, er, eu, ed;
    logic        o_hs_a   [2];
    logic        o_vs_a   [2];
    logic        o_de_a   [2];
    logic [23:0] o_data_a [2];
    logic        bv_a     [2];
    logic [15:0] drop_a   [2];

    always #5 clk = ~clk;

    plate_box_overlay u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_hs(hs), .i_vs(vs), .i_de(de), .i_x(x), .i_y(y),
        .i_data(data), .edge_left(el), .edge_right(er), .edge_up(eu), .edge_down(ed),
        .o_hs(o_hs_a[0]), .o_vs(o_vs_a[0]), .o_de(o_de_a[0]), .o_data(o_data_a[0]),
        .box_valid(bv_a[0]), .drop_cnt(drop_a[0])
    );

    plate_box_overlay #(.MIN_W(4), .HOLD_FRAMES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_hs(hs), .i_vs(vs), .i_de(de), .i_x(x), .i_y(y),
        .i_data(data), .edge_left(el), .edge_right(er), .edge_up(eu), .edge_down(ed),
        .o_hs(o_hs_a[1]), .o_vs(o_vs_a[1]), .o_de(o_de_a[1]), .o_data(o_data_a[1]),
        .box_valid(bv_a[1]), .drop_cnt(drop_a[1])
    );

    typedef struct {
        logic        hs, vs, de;
        logic [23:0] d0, d1;
    } exp_t;

    typedef struct {
        int l, r, u, d;
        int pl, pr, pu, pb;
        bit bv0;
        int dr0;
        bit bv1;
        int dr1;
    } frame_t;

    exp_t   sb[$];
    exp_t   ce;
    frame_t tbl[11];
    int     checks = 0;
    int     failures = 0;
    bit     chk_en = 1'b0;

    int m_minw [2] = '{16, 4};
    int m_hold [2] = '{3, 0};
    int st [2], hc [2], bl [2], br [2], bu [2], bd [2], mdrop [2];
    bit m_prev_vs;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            st[k] = 0; hc[k] = 0; bl[k] = 0; br[k] = 0; bu[k] = 0; bd[k] = 0; mdrop[k] = 0;
        end
        m_prev_vs = 1'b0;
    endtask

    function automatic bit box_ok(int l, int r, int u, int d, int mw);
        if (!(l < r && u < d)) return 1'b0;
        return (r - l >= mw) && (d - u >= 8) && (r - l >= 2 * T) && (d - u >= 2 * T);
    endfunction

    task automatic model_fs(int k);
        bit v;
        v = box_ok(int'(el), int'(er), int'(eu), int'(ed), m_minw[k]);
        if (!v && mdrop[k] < 65535) mdrop[k]++;
        if (v) begin
            st[k] = 1; hc[k] = 0;
            bl[k] = int'(el); br[k] = int'(er); bu[k] = int'(eu); bd[k] = int'(ed);
        end else if (st[k] == 1) begin
            if (m_hold[k] == 0) st[k] = 0;
            else begin st[k] = 2; hc[k] = 1; end
        end else if (st[k] == 2) begin
            if (hc[k] == m_hold[k]) begin st[k] = 0; hc[k] = 0; end
            else hc[k]++;
        end
    endtask

    function automatic logic [23:0] exp_pix(int k, bit e, int px, int py, logic [23:0] pd);
        bit outer, border;
        outer  = px >= bl[k] && px <= br[k] && py >= bu[k] && py <= bd[k];
        border = outer && (px < bl[k] + T || px > br[k] - T || py < bu[k] + T || py > bd[k] - T);
        return (st[k] != 0 && e && border) ? BOX : pd;
    endfunction

    task automatic step(input logic h, input logic v, input logic e, input int px, input int py,
                        input logic [23:0] pd);
        exp_t ne;
        hs = h; vs = v; de = e; x = 12'(px); y = 12'(py); data = pd;
        if (v && !m_prev_vs) begin
            model_fs(0);
            model_fs(1);
        end
        m_prev_vs = v;
        ne.hs = h; ne.vs = v; ne.de = e;
        ne.d0 = exp_pix(0, e, px, py, pd);
        ne.d1 = exp_pix(1, e, px, py, pd);
        sb.push_back(ne);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int clip(int v, int alt);
        return (v < 0 || v > 4095) ? alt : v;
    endfunction

    task automatic frame_start(input int l, input int r, input int u, input int d);
        el = 12'(l); er = 12'(r); eu = 12'(u); ed = 12'(d);
        step(1'b0, 1'b0, 1'b0, 0, 0, 24'(int'($urandom)));
        step(1'b1, 1'b0, 1'b0, 0, 0, 24'(int'($urandom)));
    endtask

    // Probes a 9x9 grid of columns/rows around the border of box (pl,pr,pu,pb)
    task automatic probe(input int pl, input int pr, input int pu, input int pb);
        int xs [9];
        int ys [9];
        int mx, my;
        mx = (pl + pr) / 2;
        my = (pu + pb) / 2;
        xs = '{pl - 1, pl, pl + 1, pl + 2, mx, pr - 2, pr - 1, pr, pr + 1};
        ys = '{pu - 1, pu, pu + 1, pu + 2, my, pb - 2, pb - 1, pb, pb + 1};
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) begin
                step(1'($urandom), 1'b1, ((i * 9 + j) % 7) != 3, clip(xs[j], mx), clip(ys[i], my),
                     24'(int'($urandom)));
            end
        end
    endtask

    // Pixel scoreboard: an entry is due two clocks after it was driven
    always @(negedge clk) begin
        if (chk_en && sb.size() >= 3) begin
            ce = sb.pop_front();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (o_hs_a[k] !== ce.hs || o_vs_a[k] !== ce.vs || o_de_a[k] !== ce.de ||
                    o_data_a[k] !== (k == 0 ? ce.d0 : ce.d1)) begin
                    failures++;
                    $display("FAIL pix dut%0d got hs=%b vs=%b de=%b data=%h expected hs=%b vs=%b de=%b data=%h",
                             k, o_hs_a[k], o_vs_a[k], o_de_a[k], o_data_a[k],
                             ce.hs, ce.vs, ce.de, (k == 0 ? ce.d0 : ce.d1));
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{100, 300, 80, 150,   100, 300, 80, 150,   1'b1, 0, 1'b1, 0};
        tbl[1]  = '{0, 0, 0, 0,          100, 300, 80, 150,   1'b1, 1, 1'b0, 1};
        tbl[2]  = '{0, 0, 0, 0,          100, 300, 80, 150,   1'b1, 2, 1'b0, 2};
        tbl[3]  = '{0, 0, 0, 0,          100, 300, 80, 150,   1'b1, 3, 1'b0, 3};
        tbl[4]  = '{0, 0, 0, 0,          100, 300, 80, 150,   1'b0, 4, 1'b0, 4};
        tbl[5]  = '{50, 60, 70, 78,      50, 60, 70, 78,      1'b0, 5, 1'b1, 4};
        tbl[6]  = '{50, 66, 70, 78,      50, 66, 70, 78,      1'b1, 5, 1'b1, 4};
        tbl[7]  = '{4090, 4095, 10, 20,  4090, 4095, 10, 20,  1'b1, 6, 1'b1, 4};
        tbl[8]  = '{300, 100, 80, 150,   50, 66, 70, 78,      1'b1, 7, 1'b0, 5};
        tbl[9]  = '{10, 26, 5, 9,        50, 66, 70, 78,      1'b1, 8, 1'b0, 6};
        tbl[10] = '{100, 300, 80, 150,   100, 300, 80, 150,   1'b1, 8, 1'b1, 6};

        rst_n = 1'b0;
        hs = 1'b0; vs = 1'b0; de = 1'b0; x = 12'd0; y = 12'd0; data = 24'd0;
        el = 12'd0; er = 12'd0; eu = 12'd0; ed = 12'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_data%0d", k), 32'(o_data_a[k]), 32'd0);
            chk($sformatf("rst_bv%0d", k), 32'(bv_a[k]), 32'd0);
            chk($sformatf("rst_drop%0d", k), 32'(drop_a[k]), 32'd0);
        end
        rst_n = 1'b1;
        chk_en = 1'b1;

        for (int f = 0; f < 11; f++) begin
            frame_start(tbl[f].l, tbl[f].r, tbl[f].u, tbl[f].d);
            probe(tbl[f].pl, tbl[f].pr, tbl[f].pu, tbl[f].pb);
            chk($sformatf("f%0d_bv0", f), 32'(bv_a[0]), 32'(tbl[f].bv0));
            chk($sformatf("f%0d_drop0", f), 32'(drop_a[0]), 32'(tbl[f].dr0));
            chk($sformatf("f%0d_bv1", f), 32'(bv_a[1]), 32'(tbl[f].bv1));
            chk($sformatf("f%0d_drop1", f), 32'(drop_a[1]), 32'(tbl[f].dr1));
        end

        // Mid-frame edge change is ignored until the next frame start
        frame_start(100, 300, 80, 150);
        step(1'b0, 1'b1, 1'b1, 99, 115, 24'h123456);
        step(1'b0, 1'b1, 1'b1, 100, 115, 24'h123456);
        step(1'b0, 1'b1, 1'b1, 101, 115, 24'h123456);
        el = 12'd200;
        step(1'b0, 1'b1, 1'b1, 100, 115, 24'h00AA55);
        step(1'b0, 1'b1, 1'b1, 200, 115, 24'h00AA55);
        step(1'b0, 1'b1, 1'b1, 201, 115, 24'h00AA55);
        chk("mid_drop0", 32'(drop_a[0]), 32'd8);
        frame_start(200, 300, 80, 150);
        probe(200, 300, 80, 150);
        step(1'b0, 1'b1, 1'b1, 100, 115, 24'h0F0F0F);
        chk("next_bv0", 32'(bv_a[0]), 32'd1);
        chk("next_drop1", 32'(drop_a[1]), 32'd6);

        // Reset in the middle of a drawn frame
        frame_start(200, 300, 80, 150);
        step(1'b1, 1'b1, 1'b1, 200, 115, 24'h777777);
        step(1'b1, 1'b1, 1'b1, 201, 115, 24'h777777);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("mrst_data%0d", k), 32'(o_data_a[k]), 32'd0);
            chk($sformatf("mrst_sync%0d", k), 32'({o_hs_a[k], o_vs_a[k], o_de_a[k]}), 32'd0);
            chk($sformatf("mrst_bv%0d", k), 32'(bv_a[k]), 32'd0);
            chk($sformatf("mrst_drop%0d", k), 32'(drop_a[k]), 32'd0);
        end
        sb.delete();
        model_reset();
        vs = 1'b0; hs = 1'b0; de = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, 200, 115, 24'h343434);
        step(1'b0, 1'b0, 1'b1, 200, 80, 24'h343434);
        step(1'b0, 1'b0, 1'b1, 300, 150, 24'h343434);
        chk("prst_drop0", 32'(drop_a[0]), 32'd0);
        frame_start(0, 0, 0, 0);
        probe(200, 300, 80, 150);
        chk("prst_inv_bv0", 32'(bv_a[0]), 32'd0);
        chk("prst_inv_drop0", 32'(drop_a[0]), 32'd1);
        frame_start(100, 300, 80, 150);
        probe(100, 300, 80, 150);
        chk("prst_ok_bv0", 32'(bv_a[0]), 32'd1);
        chk("prst_ok_drop1", 32'(drop_a[1]), 32'd1);

        repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0, 24'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
